// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame geometry.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam int unsigned DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver core: input synchronizer, bit-timing FSM and LSB-first shift register.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_serial,
    output logic                 byte_done,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int unsigned    CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  BIT_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     IDX_MAX = 3'(DATA_BITS - 1);

    logic                 rx_meta_q, rx_s_q;
    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] sr_q, sr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            sr_q      <= '0;
        end else begin
            rx_meta_q <= rx_serial;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sr_q      <= sr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        sr_d      = sr_q;
        byte_done = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // Mid-start-bit recheck rejects short glitches without flagging an error.
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d = '0;
                    sr_d  = {rx_s_q, sr_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_MAX) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s_q) begin
                        byte_done = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_byte = sr_q;
    assign rx_busy = (state_q != IDLE);

endmodule

// File: rtl/uart_rx_msg_reg.sv
// UART receive path with a single-entry message register, valid/ack handshake and overrun flag.
module uart_rx_msg_reg
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_serial,
    input  logic                 msg_ack,
    output logic [DATA_BITS-1:0] msg,
    output logic                 msg_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    logic                 byte_done;
    logic [DATA_BITS-1:0] rx_byte;
    logic                 core_ferr;

    logic [DATA_BITS-1:0] msg_q, msg_d;
    logic                 valid_q, valid_d;
    logic                 ovr_q, ovr_d;
    logic                 ferr_q;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .rx_serial (rx_serial),
        .byte_done (byte_done),
        .rx_byte   (rx_byte),
        .frame_err (core_ferr),
        .rx_busy   (rx_busy)
    );

    always_comb begin
        msg_d   = msg_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (byte_done) begin
            // An ack landing with the commit frees the slot, so the new byte replaces it.
            if (!valid_q || msg_ack) begin
                msg_d   = rx_byte;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (msg_ack && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msg_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            msg_q   <= msg_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= core_ferr;
        end
    end

    assign msg       = msg_q;
    assign msg_valid = valid_q;
    assign overrun   = ovr_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_msg_reg.sv
// Scoreboard bench for uart_rx_msg_reg: frame-level reference model feeds expected register states to a monitor.
module tb_uart_rx_msg_reg;

    localparam int CPB = 16;
    localparam int FRAME = 10 * CPB;
    // Pin edge -> sync (2) -> START entry (1) -> stop sample at HALF + 9 bit periods.
    localparam int STOP_AT   = 3 + CPB / 2 + 9 * CPB;
    localparam int GLITCH_AT = 3 + CPB / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_serial = 1'b1;
    logic       msg_ack = 1'b0;
    logic [7:0] msg;
    logic       msg_valid, frame_err, overrun, rx_busy;

    uart_rx_msg_reg #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_serial (rx_serial),
        .msg_ack   (msg_ack),
        .msg       (msg),
        .msg_valid (msg_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         cyc;
        logic [7:0] msg;
        logic       valid;
        logic       ovr;
        logic       ferr;
    } exp_t;

    exp_t sb[$];

    // Reference model of the message register, advanced one transaction at a time.
    logic [7:0] m_msg   = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ovr   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int c, input bit ferr);
        exp_t e;
        e.cyc   = c;
        e.msg   = m_msg;
        e.valid = m_valid;
        e.ovr   = m_ovr;
        e.ferr  = ferr;
        sb.push_back(e);
    endtask

    task automatic model_ack();
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic model_commit(input logic [7:0] d, input bit ack_same);
        if (!m_valid || ack_same) begin
            m_msg   = d;
            m_valid = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    // ack_c: frame-relative cycle on which msg_ack is driven (-1 for none).
    task automatic send_frame(input logic [7:0] d, input bit stop, input int ack_c);
        logic [9:0] bits;
        int start;
        bits = {stop, d, 1'b0};
        for (int c = 0; c < FRAME; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                start = cyc;
                if (ack_c >= 0 && ack_c < STOP_AT - 1) begin
                    model_ack();
                    push_exp(start + ack_c + 1, 1'b0);
                end
                if (stop) model_commit(d, ack_c == STOP_AT - 1);
                else if (ack_c == STOP_AT - 1) model_ack();
                push_exp(start + STOP_AT, !stop);
                if (!stop) push_exp(start + STOP_AT + 1 + CPB / 2, 1'b0);
                if (ack_c > STOP_AT - 1) begin
                    model_ack();
                    push_exp(start + ack_c + 1, 1'b0);
                end
            end
            rx_serial = bits[c / CPB];
            msg_ack   = (c == ack_c);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rx_serial = 1'b1;
            msg_ack   = 1'b0;
        end
    endtask

    task automatic glitch();
        for (int c = 0; c < CPB; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) push_exp(cyc + GLITCH_AT, 1'b0);
            rx_serial = (c < 4) ? 1'b0 : 1'b1;
            msg_ack   = 1'b0;
        end
    endtask

    task automatic ack_pulse();
        @(posedge clk);
        #1;
        msg_ack = 1'b1;
        model_ack();
        push_exp(cyc + 1, 1'b0);
        @(posedge clk);
        #1;
        msg_ack = 1'b0;
    endtask

    // Monitor: every end of reception (rx_busy fall) or ack consumption yields one expected state.
    bit mon_en    = 1'b0;
    bit prev_busy = 1'b0;
    bit prev_ack  = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if ((prev_busy && !rx_busy) || prev_ack) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got output event at cycle %0d, expected none", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("msg", int'(msg), int'(e.msg));
                    check("msg_valid", int'(msg_valid), int'(e.valid));
                    check("overrun", int'(overrun), int'(e.ovr));
                    check("frame_err", int'(frame_err), int'(e.ferr));
                end
            end else if (frame_err) begin
                total++;
                bad++;
                $display("FAIL spurious_frame_err: got 1 expected 0 (cycle %0d)", cyc);
            end
            prev_busy = rx_busy;
            prev_ack  = msg_ack;
        end
    end

    initial begin
        int kind, ac, wait_n;
        logic [7:0] d;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_msg", int'(msg), 0);
        check("rst_msg_valid", int'(msg_valid), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_rx_busy", int'(rx_busy), 0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        idle(3);

        send_frame(8'hAB, 1'b1, -1);
        ack_pulse();
        idle(4);

        send_frame(8'h6D, 1'b1, STOP_AT + 2);
        send_frame(8'hAB, 1'b1, STOP_AT + 2);
        idle(4);

        send_frame(8'h55, 1'b0, -1);
        idle(10);

        glitch();
        idle(3);

        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        send_frame(8'h33, 1'b1, STOP_AT - 1);
        ack_pulse();
        idle(4);

        for (int n = 0; n < 16; n++) begin
            kind = $urandom_range(0, 9);
            d    = 8'($urandom_range(0, 255));
            if (kind == 0) begin
                glitch();
            end else if (kind == 1) begin
                send_frame(d, 1'b0, -1);
                idle(10);
            end else begin
                case ($urandom_range(0, 4))
                    0:       ac = -1;
                    1:       ac = STOP_AT - 1;
                    2:       ac = 50;
                    default: ac = $urandom_range(STOP_AT, FRAME - 2);
                endcase
                send_frame(d, 1'b1, ac);
            end
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 12));
        end
        ack_pulse();
        idle(4);

        wait_n = 0;
        while (sb.size() != 0 && wait_n < 400) begin
            @(posedge clk);
            wait_n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
